// File: rtl/data_cache_pkg.sv
// Shared types and address-field helpers for the direct-mapped write-back data cache.
package cache_types;

  typedef enum logic [1:0] {IDLE, RESP, WB, FILL} state_t;

  localparam int S_INDEX_DEF = 3;
  localparam int OFFSET_W    = 5;
  localparam int WORD_W      = 32;
  localparam int WORDS       = 8;
  localparam int LINE_W      = WORD_W * WORDS;
  localparam int LINE_BYTES  = LINE_W / 8;

  function automatic int tag_width(input int s_index);
    return 32 - OFFSET_W - s_index;
  endfunction

  // Helpers return full 32-bit values; callers size-cast to the field width.
  function automatic logic [31:0] addr_set(input logic [31:0] a, input int s_index);
    return (a >> OFFSET_W) & ((32'd1 << s_index) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int s_index);
    return a >> (OFFSET_W + s_index);
  endfunction

  function automatic logic [2:0] addr_word(input logic [31:0] a);
    return a[4:2];
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// CPU-side and backing-memory-side bus of the data cache.
interface data_cache_if;
  logic         mem_read;
  logic         mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_address;
  logic [31:0]  mem_wdata;
  logic         mem_resp;
  logic [31:0]  mem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_resp, mem_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_resp, mem_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/data_cache_array.sv
// Per-set valid/dirty/tag/line storage: one combinational read port, one byte-masked write port.
module cache_array #(
  parameter int S_INDEX = 3,
  parameter int TAG_W   = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [S_INDEX-1:0] idx,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [255:0]       rd_data,
  input  logic               meta_we,
  input  logic               wr_valid,
  input  logic               wr_dirty,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [31:0]        wr_mask,
  input  logic [255:0]       wr_data
);
  localparam int SETS = 1 << S_INDEX;

  logic [SETS-1:0]  valid_q;
  logic [SETS-1:0]  dirty_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0][7:0] data_q [SETS];
  logic [31:0][7:0] wr_bytes;

  assign wr_bytes = wr_data;
  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_data  = data_q[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (meta_we) begin
      valid_q[idx] <= wr_valid;
      dirty_q[idx] <= wr_dirty;
    end
  end

  // Tag and data storage carry no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (meta_we) tag_q[idx] <= wr_tag;
    for (int b = 0; b < 32; b++)
      if (wr_mask[b]) data_q[idx][b] <= wr_bytes[b];
  end
endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache: controller FSM and datapath.
module data_cache
  import cache_types::*;
#(
  parameter int S_INDEX = S_INDEX_DEF
) (
  input  logic         clk,
  input  logic         rst,
  data_cache_if.slave  bus
);
  localparam int SET_W = S_INDEX;
  localparam int TAG_W = tag_width(S_INDEX);

  state_t state, state_n;

  logic [31:0]       miss_addr, cur_addr, rdata_q;
  logic [SET_W-1:0]  idx;
  logic [TAG_W-1:0]  req_tag, rd_tag, wr_tag;
  logic [2:0]        word;
  logic [255:0]      rd_data, wr_data;
  logic [7:0][31:0]  rd_words;
  logic [31:0]       wr_mask;
  logic              rd_valid, rd_dirty, wr_valid, wr_dirty, meta_we;
  logic              req, hit, rdata_ld;

  // Once a miss is taken the line address is held, so a CPU that drops or
  // changes its request mid-refill still gets a coherent install.
  assign cur_addr = (state == IDLE) ? bus.mem_address : miss_addr;
  assign idx      = SET_W'(addr_set(cur_addr, S_INDEX));
  assign req_tag  = TAG_W'(addr_tag(cur_addr, S_INDEX));
  assign word     = addr_word(bus.mem_address);
  assign req      = bus.mem_read | bus.mem_write;
  assign hit      = rd_valid && (rd_tag == req_tag);
  assign rd_words = rd_data;

  cache_array #(.S_INDEX(S_INDEX), .TAG_W(TAG_W)) u_array (
    .clk      (clk),
    .rst      (rst),
    .idx      (idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .meta_we  (meta_we & ~rst),
    .wr_valid (wr_valid),
    .wr_dirty (wr_dirty),
    .wr_tag   (wr_tag),
    .wr_mask  (rst ? '0 : wr_mask),
    .wr_data  (wr_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rdata_q   <= '0;
      miss_addr <= '0;
    end else begin
      state <= state_n;
      if (rdata_ld)      rdata_q   <= rd_words[word];
      if (state == IDLE) miss_addr <= bus.mem_address;
    end
  end

  always_comb begin
    state_n          = state;
    meta_we          = 1'b0;
    wr_valid         = rd_valid;
    wr_dirty         = rd_dirty;
    wr_tag           = rd_tag;
    wr_mask          = '0;
    wr_data          = {WORDS{bus.mem_wdata}};
    rdata_ld         = 1'b0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    unique case (state)
      IDLE: if (req) begin
        if (hit) begin
          state_n = RESP;
          // Write wins when both strobes are high.
          if (bus.mem_write) begin
            meta_we  = 1'b1;
            wr_dirty = 1'b1;
            wr_mask  = {28'b0, bus.mem_byte_enable} << {word, 2'b00};
          end else begin
            rdata_ld = 1'b1;
          end
        end else if (rd_valid && rd_dirty) begin
          state_n = WB;
        end else begin
          state_n = FILL;
        end
      end
      RESP: state_n = IDLE;
      WB: begin
        bus.pmem_write   = 1'b1;
        bus.pmem_address = {rd_tag, idx, 5'b0};
        bus.pmem_wdata   = rd_data;
        if (bus.pmem_resp) begin
          meta_we  = 1'b1;
          wr_dirty = 1'b0;
          state_n  = FILL;
        end
      end
      FILL: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = {req_tag, idx, 5'b0};
        if (bus.pmem_resp) begin
          meta_we  = 1'b1;
          wr_valid = 1'b1;
          wr_dirty = 1'b0;
          wr_tag   = req_tag;
          wr_mask  = '1;
          wr_data  = bus.pmem_rdata;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.mem_resp  = (state == RESP);
  assign bus.mem_rdata = rdata_q;
endmodule

// File: tb/tb_data_cache.sv
// Random and directed scoreboard bench for data_cache against a flat-memory reference model.
module tb_data_cache;
  typedef struct { bit chk; logic [31:0] data; } exp_t;
  typedef struct { bit wr; logic [31:0] addr; logic [255:0] data; time t; } pm_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_cache_if bus();
  data_cache #(.S_INDEX(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0, errors = 0;
  exp_t exp_q[$];
  int   rd_idx = 0;
  pm_t  pm_log[$];
  logic [31:0] last_rdata = '0;

  // Backing memory, plus the reference's CPU-visible view and its own idea of backing contents.
  logic [255:0] bmem     [logic [31:0]];
  logic [31:0]  ref_mem  [logic [31:0]];
  logic [31:0]  ref_back [logic [31:0]];
  bit           res_v [8];
  bit           res_d [8];
  logic [31:0]  res_tag [8];

  int pm_lat = 1;
  bit pm_auto = 1'b1;
  int kick_req = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h104) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [255:0] back_line(input logic [31:0] la);
    logic [255:0] l;
    if (bmem.exists(la)) return bmem[la];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(la + 32'(4*w));
    return l;
  endfunction

  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [255:0] ref_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = rd_ref(la + 32'(4*w));
    return l;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Reset discards everything the cache held; the CPU view falls back to backing memory.
  task automatic model_reset();
    ref_mem.delete();
    foreach (ref_back[k]) ref_mem[k] = ref_back[k];
    for (int s = 0; s < 8; s++) begin res_v[s] = 0; res_d[s] = 0; end
  endtask

  // Backing-memory responder: one pulse after pm_lat cycles of a held request.
  initial begin
    int cnt = 0;
    int kick_done = 0;
    pm_t ev;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.pmem_resp) begin
        bus.pmem_resp = 1'b0;
        cnt = 0;
      end else if (kick_done != kick_req) begin
        kick_done = kick_req;
        bus.pmem_rdata = '1;
        bus.pmem_resp  = 1'b1;
      end else if (pm_auto && !rst && (bus.pmem_read || bus.pmem_write)) begin
        cnt++;
        if (cnt >= pm_lat) begin
          ev.wr = bus.pmem_write; ev.addr = bus.pmem_address; ev.t = $time;
          if (bus.pmem_write) begin
            ev.data = bus.pmem_wdata;
            bmem[bus.pmem_address] = bus.pmem_wdata;
          end else begin
            ev.data = back_line(bus.pmem_address);
            bus.pmem_rdata = ev.data;
          end
          pm_log.push_back(ev);
          bus.pmem_resp = 1'b1;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the cache completes a CPU request.
  always @(negedge clk) begin
    if (bus.pmem_read && bus.pmem_write) begin
      errors++;
      $display("FAIL pmem_exclusive read=%0b write=%0b", bus.pmem_read, bus.pmem_write);
    end
    if (bus.mem_resp) begin
      if (rd_idx >= exp_q.size()) begin
        errors++;
        $display("FAIL unexpected_resp rdata=%0h", bus.mem_rdata);
      end else begin
        last_rdata = bus.mem_rdata;
        if (exp_q[rd_idx].chk) chk("rdata", bus.mem_rdata, exp_q[rd_idx].data);
        rd_idx++;
      end
    end
  end

  task automatic cpu_op(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd,
                        output int lat, output time t_resp, output int base);
    logic [31:0] a, ltag, vic;
    logic [255:0] vic_line;
    int set, n;
    bit hit, wb, got;
    exp_t e;
    a = {addr[31:2], 2'b00};
    set = int'((a >> 5) & 32'd7);
    ltag = a >> 8;
    hit = res_v[set] && res_tag[set] == ltag;
    wb = !hit && res_v[set] && res_d[set];
    vic = (res_tag[set] << 8) | 32'(set << 5);
    vic_line = ref_line(vic);
    if (wb) for (int w = 0; w < 8; w++) ref_back[vic + 32'(4*w)] = rd_ref(vic + 32'(4*w));
    e.chk = !wr;
    e.data = rd_ref(a);
    if (wr) begin
      logic [31:0] nv = rd_ref(a);
      for (int b = 0; b < 4; b++) if (be[b]) nv[b*8 +: 8] = wd[b*8 +: 8];
      ref_mem[a] = nv;
    end
    res_v[set] = 1; res_tag[set] = ltag;
    if (wr) res_d[set] = 1; else if (!hit) res_d[set] = 0;
    exp_q.push_back(e);
    base = pm_log.size();

    @(posedge clk); #1;
    bus.mem_read = rd; bus.mem_write = wr; bus.mem_address = addr;
    bus.mem_byte_enable = be; bus.mem_wdata = wd;
    n = 0; got = 0; t_resp = 0;
    while (!got && n < 300) begin
      @(negedge clk); n++;
      if (bus.mem_resp) begin got = 1; t_resp = $time; end
    end
    lat = n - 1;
    if (!got) begin
      errors++;
      $display("FAIL timeout addr=%0h waited=%0d", addr, n);
    end
    @(posedge clk); #1;
    bus.mem_read = 0; bus.mem_write = 0;

    if (hit) begin
      chk("hit_latency", 256'(lat), 256'(1));
      chk("hit_no_pmem", 256'(pm_log.size() - base), 256'(0));
    end else begin
      chk("miss_pmem_count", 256'(pm_log.size() - base), 256'(wb ? 2 : 1));
      if (pm_log.size() - base == (wb ? 2 : 1)) begin
        if (wb) begin
          chk("wb_is_write", 256'(pm_log[base].wr), 256'(1));
          chk("wb_addr", 256'(pm_log[base].addr), 256'(vic));
          chk("wb_data", pm_log[base].data, vic_line);
        end
        chk("fill_is_read", 256'(pm_log[base + (wb ? 1 : 0)].wr), 256'(0));
        chk("fill_addr", 256'(pm_log[base + (wb ? 1 : 0)].addr), 256'(a & ~32'h1F));
      end
    end
  endtask

  initial begin
    int lat, base, n;
    time tr;
    bus.mem_read = 0; bus.mem_write = 0; bus.mem_address = '0;
    bus.mem_byte_enable = '0; bus.mem_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_mem_resp", 256'(bus.mem_resp), 256'(0));
    chk("rst_pmem_read", 256'(bus.pmem_read), 256'(0));
    chk("rst_pmem_write", 256'(bus.pmem_write), 256'(0));
    chk("rst_mem_rdata", 256'(bus.mem_rdata), 256'(0));

    // Cold miss, fill, and response two cycles after the backing-memory pulse.
    cpu_op(1, 0, 32'h104, 4'h0, 32'h0, lat, tr, base);
    chk("first_fill_addr", 256'(pm_log[base].addr), 256'(32'h100));
    chk("fill_to_resp", 256'(tr - pm_log[base].t), 256'(20));
    chk("first_rdata", 256'(last_rdata), 256'(32'hDEADBEEF));
    cpu_op(1, 0, 32'h104, 4'h0, 32'h0, lat, tr, base);
    chk("rehit_rdata", 256'(last_rdata), 256'(32'hDEADBEEF));
    cpu_op(0, 1, 32'h104, 4'b0011, 32'h12345678, lat, tr, base);
    cpu_op(1, 0, 32'h104, 4'h0, 32'h0, lat, tr, base);
    chk("merge_rdata", 256'(last_rdata), 256'(32'hDEAD5678));
    // Conflict miss on a dirty line: writeback then refill.
    cpu_op(1, 0, 32'h1104, 4'h0, 32'h0, lat, tr, base);
    chk("evict_word1", 256'(pm_log[base].data[63:32]), 256'(32'hDEAD5678));

    // Reset in the middle of a refill; a late pulse must not disturb the idle cache.
    pm_auto = 0;
    @(posedge clk); #1;
    bus.mem_read = 1; bus.mem_address = 32'h104;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.pmem_read && n < 50);
    chk("abort_fill_req", 256'(bus.pmem_read), 256'(1));
    chk("abort_fill_addr", 256'(bus.pmem_address), 256'(32'h100));
    @(posedge clk); #1 rst = 1; bus.mem_read = 0;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("abort_read_low", 256'(bus.pmem_read), 256'(0));
    kick_req++;
    repeat (3) @(negedge clk);
    chk("late_resp_read", 256'(bus.pmem_read), 256'(0));
    chk("late_resp_write", 256'(bus.pmem_write), 256'(0));
    model_reset();
    pm_auto = 1;
    cpu_op(1, 0, 32'h104, 4'h0, 32'h0, lat, tr, base);

    // Both strobes high is a write.
    cpu_op(1, 1, 32'h104, 4'hF, 32'hCAFEF00D, lat, tr, base);
    cpu_op(1, 0, 32'h104, 4'h0, 32'h0, lat, tr, base);
    chk("both_is_write", 256'(last_rdata), 256'(32'hCAFEF00D));

    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra;
      int op;
      ra = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 5) | ($urandom_range(0, 7) << 2);
      op = $urandom_range(0, 4);
      pm_lat = $urandom_range(1, 3);
      cpu_op(op < 2, op >= 2, op == 4 ? ra | 32'h3 : ra, 4'($urandom), $urandom, lat, tr, base);
    end

    repeat (5) @(negedge clk);
    chk("all_responses", 256'(rd_idx), 256'(exp_q.size()));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter S_INDEX, default 3, log2 of set count (8 sets).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 mem_read  input  1  CPU data read request, held until mem_resp.
REQ-005 mem_write  input  1  CPU data write request, held until mem_resp.
REQ-006 mem_byte_enable  input  4  byte lanes written on write.
REQ-007 mem_address  input  32  byte address; bits [1:0] ignored.
REQ-008 mem_wdata  input  32  write data.
REQ-009 mem_resp  output  1  one-cycle completion pulse.
REQ-010 mem_rdata  output  32  read data, valid while mem_resp=1.
REQ-011 pmem_read / pmem_write  output  1 each  line fill / writeback request, held until pmem_resp.
REQ-012 pmem_address  output  32  line address, bits [4:0]=0.
REQ-013 pmem_wdata  output  256  victim line.
REQ-014 pmem_rdata  input  256  fill line, valid with pmem_resp.
REQ-015 pmem_resp  input  1  backing-memory completion pulse.

Function
REQ-016 Direct-mapped, write-back, write-allocate; 32-byte lines; offset [4:0], word select [4:2], set [4+S_INDEX:5], tag [31:5+S_INDEX] (24 bits at default).
REQ-017 Per set: valid, dirty, tag, 256-bit data.
REQ-018 States: IDLE, RESP, WB, FILL.
REQ-019 IDLE, no request: stay; all outputs low.
REQ-020 IDLE, request, hit (valid and tag match): read latches addressed word into mem_rdata register; write merges mem_wdata per byte enable into the word and sets dirty; go RESP.
REQ-021 RESP: mem_resp=1 for exactly one cycle; go IDLE; hit latency = 1 cycle from request sample to mem_resp.
REQ-022 IDLE, miss, victim valid and dirty: go WB; else go FILL.
REQ-023 WB: pmem_write=1, pmem_address={victim tag, set, 5'b0}, pmem_wdata=victim line; on pmem_resp clear dirty, go FILL.
REQ-024 FILL: pmem_read=1, pmem_address={req tag, set, 5'b0}; on pmem_resp store line, set valid, clear dirty, write tag, go IDLE (request re-evaluated as hit).
REQ-025 pmem_read and pmem_write never asserted together; neither asserted outside WB/FILL.
REQ-026 mem_read and mem_write both high: treated as write.
REQ-027 Request dropped by CPU while in WB/FILL: transaction completes, line installed, no mem_resp.
REQ-028 mem_address, mem_wdata, mem_byte_enable sampled combinationally each cycle; CPU holds them stable until mem_resp.
REQ-029 Write with mem_byte_enable=4'b0000: completes as hit/miss normally, data unchanged, dirty set.

Reset
REQ-030 rst high: state to IDLE, all valid and dirty bits cleared next edge, mem_resp, pmem_read, pmem_write low the following cycle; mem_rdata reset to 0.
REQ-031 Reset mid-WB/FILL: transaction abandoned, dirty data discarded, late pmem_resp ignored.
REQ-032 Tag and data arrays not reset.

Structure
REQ-033 Package cache_types: state enum, S_INDEX default, line/tag/offset width constants, address-field extraction functions.
REQ-034 One sub-module cache_array: tag/valid/dirty/data storage, single read port, byte-masked line write port; controller and datapath in data_cache.

Verification
REQ-035 After reset, read 0x0000_0104 -> pmem_read, pmem_address 0x0000_0100; return line word1=0xDEADBEEF -> mem_resp, mem_rdata 0xDEADBEEF, 2 cycles after pmem_resp.
REQ-036 Repeat read 0x0000_0104 -> mem_resp next cycle, 0xDEADBEEF, no pmem activity.
REQ-037 Write 0x0000_0104, be 4'b0011, wdata 0x1234_5678 -> resp in 1 cycle; read -> 0xDEAD5678.
REQ-038 Read 0x0000_1104 -> pmem_write to 0x0000_0100, word1 0xDEAD5678, then pmem_read 0x0000_1100, then mem_resp.
REQ-039 rst during FILL -> pmem_read low next cycle; late pmem_resp ignored; read 0x0000_0104 then misses again.
REQ-040 mem_read and mem_write high together at 0x0000_0104 -> write performed; no simultaneous pmem_read/pmem_write in any test (assertion).
